// File: rtl/e203_icb_arb_pkg.sv
// rtl/e203_icb_arb_pkg.sv - shared master-ID type and defaults for the DMA/LSU ICB arbiter
package e203_icb_arb_pkg;

    typedef logic icb_id_t;

    localparam icb_id_t M0_ID = 1'b0;
    localparam icb_id_t M1_ID = 1'b1;

    localparam int OUTS_DEPTH_DEF = 2;

endpackage

// File: rtl/e203_icb_arb_idfifo.sv
// rtl/e203_icb_arb_idfifo.sv - in-order FIFO of master IDs for accepted commands
module e203_icb_arb_idfifo
    import e203_icb_arb_pkg::*;
#(
    parameter int DEPTH = OUTS_DEPTH_DEF
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  icb_id_t push_id,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output icb_id_t head_id
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    icb_id_t            mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head_id = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/e203_dma_icb_arb.sv
// rtl/e203_dma_icb_arb.sv - LSU/DMA to SRAM ICB arbiter; E203_DMA_ICB_ARB_RR_EN selects round-robin
module e203_dma_icb_arb
    import e203_icb_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int OUTS_DEPTH = OUTS_DEPTH_DEF
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                m0_icb_cmd_valid,
    output logic                m0_icb_cmd_ready,
    input  logic [ADDR_W-1:0]   m0_icb_cmd_addr,
    input  logic                m0_icb_cmd_read,
    input  logic [DATA_W-1:0]   m0_icb_cmd_wdata,
    input  logic [DATA_W/8-1:0] m0_icb_cmd_wmask,
    output logic                m0_icb_rsp_valid,
    input  logic                m0_icb_rsp_ready,
    output logic                m0_icb_rsp_err,
    output logic [DATA_W-1:0]   m0_icb_rsp_rdata,

    input  logic                m1_icb_cmd_valid,
    output logic                m1_icb_cmd_ready,
    input  logic [ADDR_W-1:0]   m1_icb_cmd_addr,
    input  logic                m1_icb_cmd_read,
    input  logic [DATA_W-1:0]   m1_icb_cmd_wdata,
    input  logic [DATA_W/8-1:0] m1_icb_cmd_wmask,
    output logic                m1_icb_rsp_valid,
    input  logic                m1_icb_rsp_ready,
    output logic                m1_icb_rsp_err,
    output logic [DATA_W-1:0]   m1_icb_rsp_rdata,

    output logic                s_icb_cmd_valid,
    input  logic                s_icb_cmd_ready,
    output logic [ADDR_W-1:0]   s_icb_cmd_addr,
    output logic                s_icb_cmd_read,
    output logic [DATA_W-1:0]   s_icb_cmd_wdata,
    output logic [DATA_W/8-1:0] s_icb_cmd_wmask,
    input  logic                s_icb_rsp_valid,
    output logic                s_icb_rsp_ready,
    input  logic                s_icb_rsp_err,
    input  logic [DATA_W-1:0]   s_icb_rsp_rdata
);

    logic    full, empty, gnt_valid, cmd_hs, rsp_hs, rsp_en, lock_q;
    icb_id_t head_id, lock_id, win, tie_win;

`ifdef E203_DMA_ICB_ARB_RR_EN
    icb_id_t last_gnt;

    assign tie_win = (last_gnt == M0_ID) ? M1_ID : M0_ID;

    always_ff @(posedge clk) begin
        if (rst)         last_gnt <= M1_ID;
        else if (cmd_hs) last_gnt <= win;
    end
`else
    assign tie_win = M0_ID;
`endif

    always_comb begin
        win = M0_ID;
        if (lock_q)                                     win = lock_id;
        else if (m0_icb_cmd_valid && m1_icb_cmd_valid)  win = tie_win;
        else if (m1_icb_cmd_valid)                      win = M1_ID;
    end

    // A full ID FIFO blocks the grant outright so the cmd path never depends on rsp_ready.
    assign gnt_valid = ~rst & ~full & ((win == M1_ID) ? m1_icb_cmd_valid : m0_icb_cmd_valid);
    assign cmd_hs    = gnt_valid & s_icb_cmd_ready;

    assign s_icb_cmd_valid  = gnt_valid;
    assign s_icb_cmd_addr   = (win == M1_ID) ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
    assign s_icb_cmd_read   = (win == M1_ID) ? m1_icb_cmd_read  : m0_icb_cmd_read;
    assign s_icb_cmd_wdata  = (win == M1_ID) ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
    assign s_icb_cmd_wmask  = (win == M1_ID) ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;
    assign m0_icb_cmd_ready = cmd_hs & (win == M0_ID);
    assign m1_icb_cmd_ready = cmd_hs & (win == M1_ID);

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q  <= 1'b0;
            lock_id <= M0_ID;
        end else if (gnt_valid && !s_icb_cmd_ready) begin
            lock_q  <= 1'b1;
            lock_id <= win;
        end else if (cmd_hs) begin
            lock_q  <= 1'b0;
        end
    end

    assign rsp_en           = ~rst & ~empty;
    assign s_icb_rsp_ready  = rsp_en & ((head_id == M1_ID) ? m1_icb_rsp_ready : m0_icb_rsp_ready);
    assign m0_icb_rsp_valid = rsp_en & (head_id == M0_ID) & s_icb_rsp_valid;
    assign m1_icb_rsp_valid = rsp_en & (head_id == M1_ID) & s_icb_rsp_valid;
    assign m0_icb_rsp_err   = s_icb_rsp_err;
    assign m1_icb_rsp_err   = s_icb_rsp_err;
    assign m0_icb_rsp_rdata = s_icb_rsp_rdata;
    assign m1_icb_rsp_rdata = s_icb_rsp_rdata;
    assign rsp_hs           = s_icb_rsp_valid & s_icb_rsp_ready;

    e203_icb_arb_idfifo #(
        .DEPTH   (OUTS_DEPTH)
    ) u_idfifo (
        .clk     (clk),
        .rst     (rst),
        .push    (cmd_hs),
        .push_id (win),
        .pop     (rsp_hs),
        .full    (full),
        .empty   (empty),
        .head_id (head_id)
    );

endmodule

// File: tb/tb_e203_dma_icb_arb.sv
// tb/tb_e203_dma_icb_arb.sv - self-checking bench for e203_dma_icb_arb
module tb_e203_dma_icb_arb;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cmd_valid, m0_cmd_ready, m0_cmd_read, m0_rsp_valid, m0_rsp_ready, m0_rsp_err;
    logic [31:0] m0_cmd_addr, m0_cmd_wdata, m0_rsp_rdata;
    logic [3:0]  m0_cmd_wmask;
    logic        m1_cmd_valid, m1_cmd_ready, m1_cmd_read, m1_rsp_valid, m1_rsp_ready, m1_rsp_err;
    logic [31:0] m1_cmd_addr, m1_cmd_wdata, m1_rsp_rdata;
    logic [3:0]  m1_cmd_wmask;
    logic        s_cmd_valid, s_cmd_ready, s_cmd_read, s_rsp_valid, s_rsp_ready, s_rsp_err;
    logic [31:0] s_cmd_addr, s_cmd_wdata, s_rsp_rdata;
    logic [3:0]  s_cmd_wmask;

    always #5 clk = ~clk;

    e203_dma_icb_arb #(.ADDR_W(32), .DATA_W(32), .OUTS_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .m0_icb_cmd_valid(m0_cmd_valid), .m0_icb_cmd_ready(m0_cmd_ready), .m0_icb_cmd_addr(m0_cmd_addr),
        .m0_icb_cmd_read(m0_cmd_read), .m0_icb_cmd_wdata(m0_cmd_wdata), .m0_icb_cmd_wmask(m0_cmd_wmask),
        .m0_icb_rsp_valid(m0_rsp_valid), .m0_icb_rsp_ready(m0_rsp_ready), .m0_icb_rsp_err(m0_rsp_err),
        .m0_icb_rsp_rdata(m0_rsp_rdata),
        .m1_icb_cmd_valid(m1_cmd_valid), .m1_icb_cmd_ready(m1_cmd_ready), .m1_icb_cmd_addr(m1_cmd_addr),
        .m1_icb_cmd_read(m1_cmd_read), .m1_icb_cmd_wdata(m1_cmd_wdata), .m1_icb_cmd_wmask(m1_cmd_wmask),
        .m1_icb_rsp_valid(m1_rsp_valid), .m1_icb_rsp_ready(m1_rsp_ready), .m1_icb_rsp_err(m1_rsp_err),
        .m1_icb_rsp_rdata(m1_rsp_rdata),
        .s_icb_cmd_valid(s_cmd_valid), .s_icb_cmd_ready(s_cmd_ready), .s_icb_cmd_addr(s_cmd_addr),
        .s_icb_cmd_read(s_cmd_read), .s_icb_cmd_wdata(s_cmd_wdata), .s_icb_cmd_wmask(s_cmd_wmask),
        .s_icb_rsp_valid(s_rsp_valid), .s_icb_rsp_ready(s_rsp_ready), .s_icb_rsp_err(s_rsp_err),
        .s_icb_rsp_rdata(s_rsp_rdata)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // Directed table: inputs {m0v,m1v,s_cmd_ready,s_rsp_valid,m0_rsp_ready,m1_rsp_ready},
    // expected {m0_cmd_ready,m1_cmd_ready,s_cmd_valid,s_rsp_ready,m0_rsp_valid,m1_rsp_valid}.
    typedef struct packed {
        logic [5:0] in;
        logic [5:0] exp;
    } vec_t;
    vec_t tbl [9];

    // Reference model: outstanding IDs in order, the master holding a stalled grant, last grant.
    int q[$];
    int lock_holder;
    int last_g;

    task automatic model_eval(output logic e_sv, output logic e_r0, output logic e_r1,
                              output logic e_srr, output logic e_rv0, output logic e_rv1,
                              output int win);
        win = -1;
        if (q.size() < DEPTH) begin
            if (lock_holder >= 0) win = lock_holder;
            else if (m0_cmd_valid && m1_cmd_valid) begin
`ifdef E203_DMA_ICB_ARB_RR_EN
                win = (last_g == 0) ? 1 : 0;
`else
                win = 0;
`endif
            end
            else if (m0_cmd_valid) win = 0;
            else if (m1_cmd_valid) win = 1;
        end
        e_sv = (win == 0) ? m0_cmd_valid : (win == 1) ? m1_cmd_valid : 1'b0;
        e_r0 = e_sv && win == 0 && s_cmd_ready;
        e_r1 = e_sv && win == 1 && s_cmd_ready;
        if (q.size() == 0) begin
            e_srr = 0; e_rv0 = 0; e_rv1 = 0;
        end else begin
            e_srr = (q[0] == 1) ? m1_rsp_ready : m0_rsp_ready;
            e_rv0 = (q[0] == 0) && s_rsp_valid;
            e_rv1 = (q[0] == 1) && s_rsp_valid;
        end
    endtask

    task automatic idle_inputs();
        m0_cmd_valid = 0; m1_cmd_valid = 0; s_cmd_ready = 0; s_rsp_valid = 0;
        m0_rsp_ready = 0; m1_rsp_ready = 0; s_rsp_err = 0; s_rsp_rdata = 32'hDEADBEEF;
        m0_cmd_addr = 32'h100; m1_cmd_addr = 32'h200; m0_cmd_read = 1; m1_cmd_read = 0;
        m0_cmd_wdata = 32'h1111; m1_cmd_wdata = 32'h2222; m0_cmd_wmask = 4'hF; m1_cmd_wmask = 4'h3;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        idle_inputs();
        @(negedge clk);
        rst = 0;
        q.delete();
        lock_holder = -1;
        last_g = 1;
    endtask

    task automatic apply_in(input logic [5:0] v);
        {m0_cmd_valid, m1_cmd_valid, s_cmd_ready, s_rsp_valid, m0_rsp_ready, m1_rsp_ready} = v;
    endtask

    function automatic logic [5:0] outs();
        return {m0_cmd_ready, m1_cmd_ready, s_cmd_valid, s_rsp_ready, m0_rsp_valid, m1_rsp_valid};
    endfunction

    initial begin
        logic e_sv, e_r0, e_r1, e_srr, e_rv0, e_rv1;
        logic acc0, acc1;
        int   win;

        tbl[0] = {6'b101011, 6'b101000};
        tbl[1] = {6'b011111, 6'b011110};
        tbl[2] = {6'b110011, 6'b001100};
        tbl[3] = {6'b111011, 6'b101100};
        tbl[4] = {6'b111011, 6'b000100};
        tbl[5] = {6'b111110, 6'b000001};
        tbl[6] = {6'b111111, 6'b000101};
`ifdef E203_DMA_ICB_ARB_RR_EN
        tbl[7] = {6'b111111, 6'b011110};
`else
        tbl[7] = {6'b111111, 6'b101110};
`endif
        tbl[8] = {6'b111011, 6'b101100};

        rst = 1;
        idle_inputs();
        @(negedge clk);
        chk("reset_outs", 32'(outs()), 32'h0);
        do_reset();

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            apply_in(tbl[i].in);
            #1;
            chk($sformatf("row%0d", i), 32'(outs()), 32'(tbl[i].exp));
            if (i == 1) chk("row1_rdata", m0_rsp_rdata, 32'hDEADBEEF);
        end

        // Lock: m1 stalls three cycles while m0 raises valid; m0 wins only afterwards.
        do_reset();
        @(negedge clk); m1_cmd_valid = 1; #1;
        chk("lock_c1_addr", s_cmd_addr, 32'h200);
        chk("lock_c1_valid", 32'(s_cmd_valid), 32'h1);
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk); m0_cmd_valid = 1; #1;
            chk($sformatf("lock_c%0d_addr", c), s_cmd_addr, 32'h200);
            chk($sformatf("lock_c%0d_m0rdy", c), 32'(m0_cmd_ready), 32'h0);
        end
        @(negedge clk); s_cmd_ready = 1; #1;
        chk("lock_c4_rdy", 32'({m0_cmd_ready, m1_cmd_ready}), 32'h1);
        @(negedge clk); m1_cmd_valid = 0; #1;
        chk("lock_c5_rdy", 32'({m0_cmd_ready, m1_cmd_ready}), 32'h2);
        chk("lock_c5_addr", s_cmd_addr, 32'h100);

        // Reset with two outstanding commands.
        @(negedge clk);
        rst = 1; m0_cmd_valid = 1; m1_cmd_valid = 1; s_rsp_valid = 1; m0_rsp_ready = 1; m1_rsp_ready = 1;
        #1;
        chk("rst_mid_outs", 32'(outs()), 32'h0);
        @(negedge clk);
        rst = 0; m0_cmd_valid = 0; m1_cmd_valid = 0;
        #1;
        chk("rst_fifo_empty", 32'({s_rsp_ready, m0_rsp_valid, m1_rsp_valid}), 32'h0);

        // Randomized run against the model; masters hold valid until accepted.
        do_reset();
        acc0 = 0; acc1 = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (acc0) m0_cmd_valid = 0;
            if (acc1) m1_cmd_valid = 0;
            if (!m0_cmd_valid && $urandom_range(0, 2) == 0) begin
                m0_cmd_valid = 1; m0_cmd_addr = $urandom; m0_cmd_read = 1'($urandom);
            end
            if (!m1_cmd_valid && $urandom_range(0, 2) == 0) begin
                m1_cmd_valid = 1; m1_cmd_addr = $urandom; m1_cmd_read = 1'($urandom);
            end
            s_cmd_ready  = ($urandom_range(0, 3) != 0);
            s_rsp_valid  = 1'($urandom);
            s_rsp_rdata  = $urandom;
            m0_rsp_ready = ($urandom_range(0, 3) != 0);
            m1_rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            model_eval(e_sv, e_r0, e_r1, e_srr, e_rv0, e_rv1, win);
            chk("rnd_outs", 32'(outs()), 32'({e_r0, e_r1, e_sv, e_srr, e_rv0, e_rv1}));
            if (e_sv) begin
                chk("rnd_addr", s_cmd_addr, (win == 0) ? m0_cmd_addr : m1_cmd_addr);
                chk("rnd_read", 32'(s_cmd_read), 32'((win == 0) ? m0_cmd_read : m1_cmd_read));
            end
            if (e_rv0) chk("rnd_rdata0", m0_rsp_rdata, s_rsp_rdata);
            if (e_rv1) chk("rnd_rdata1", m1_rsp_rdata, s_rsp_rdata);
            acc0 = e_r0;
            acc1 = e_r1;
            @(posedge clk);
            if (s_rsp_valid && e_srr) void'(q.pop_front());
            if (e_sv && !s_cmd_ready) lock_holder = win;
            if (e_sv && s_cmd_ready) begin
                lock_holder = -1;
                last_g = win;
                q.push_back(win);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
